prbs_gen_chk: RTL
=================

// Module: prbs_gen_chk
// PURPOSE
//  Multi-order, N-bit-parallel PRBS generator plus self-synchronising checker for link/BER tests.
//  Generator: pattern source in the TX datapath, advanced by a baud/word enable.
//  Checker: sits on the RX side, locks to the incoming PRBS, reports per-bit errors and a
//  saturating error count. Order is run-time selectable.
// PARAMETERS
//  NB_PAR     1          bits produced/checked per enable (1..32)
//  SEED       31'h1AA    generator load value; low ORDER bits used; 0 there -> load 1
//  LOCK_CNT   8          consecutive error-free valid words, SEARCH -> LOCKED
//  UNLOCK_CNT 4          consecutive errored valid words, LOCKED -> SEARCH
//  CNT_W      32         error counter width
// PORTS
//  i_clk         in   1        clock
//  i_reset       in   1        asynchronous, active-high reset
//  i_order_sel   in   3        0:PRBS7 1:PRBS9 2:PRBS15 3:PRBS23 4:PRBS31; 5-7 treated as PRBS31
//  i_enable      in   1        advance generator NB_PAR steps
//  o_data        out  NB_PAR   generator bits; [NB_PAR-1] = earliest in time
//  i_rx_valid    in   1        i_rx_data qualifier
//  i_rx_data     in   NB_PAR   received bits; [NB_PAR-1] = earliest
//  i_clr_cnt     in   1        synchronous clear of o_err_cnt
//  o_locked      out  1        checker in LOCKED
//  o_err_bits    out  NB_PAR   per-bit mismatch of last valid word (registered)
//  o_err_cnt     out  CNT_W    bit errors counted while LOCKED, saturating
// BEHAVIOUR
//  Polynomials (order:tap): 7:6, 9:5, 15:14, 23:18, 31:28. Serial step on N-bit reg r:
//   out = r[N-1]; r <= {r[N-2:0], r[N-1]^r[tap-1]}. Parallel = NB_PAR serial steps unrolled
//   in one cycle. Bits above N are held at 0.
//  Generator: reset -> r = SEED[N-1:0] (1 if zero). o_data is read combinationally from r
//   (no extra stage): o_data[NB_PAR-1-k] = bit serial step k would emit. No enable -> hold.
//  Checker: history reg h (31b) of received bits. For each bit k of a valid word, in time
//   order: pred = h[N-1]^h[tap-1]; err_k = rx_k ^ pred; h shifts in rx_k (received bit, not
//   pred). o_err_bits is registered 1 cycle after i_rx_valid; it holds while valid is low.
//  Word good = no err bits AND h[N-1:0] != 0 after the update (blocks lock on all-zero input).
//  FSM: SEARCH: good -> cnt++, else cnt=0; cnt==LOCK_CNT -> LOCKED, cnt=0.
//   LOCKED: errored word -> cnt++, else cnt=0; cnt==UNLOCK_CNT -> SEARCH, cnt=0.
//   o_locked registered, reflects state.
//  o_err_cnt: += popcount(err) on valid words while LOCKED (including the word that causes
//   unlock), saturates at 2^CNT_W-1. i_clr_cnt wins over an increment in the same cycle.
//  Order change: i_order_sel is registered; a change forces, next cycle, generator reload with
//   SEED, h cleared, FSM -> SEARCH, cnt=0. o_err_cnt is kept.
//  Reset (any time, mid-word included): r = SEED; h = 0; SEARCH; o_locked = 0;
//   o_err_bits = 0; o_err_cnt = 0; order reg = PRBS7.
//  i_enable and i_rx_valid are independent; both may be high in the same cycle.
// STRUCTURE
//  prbs_pkg: order codes, ORDER/TAP lookup functions, MAX_ORDER=31, FSM state encodings.
//  One sub-module prbs_step: combinational NB_PAR-step unroll (state, order, rx bits, mode
//   gen/chk) -> next state, out bits, err bits. Instantiated twice: generator and checker.
// TESTING
//  T1 NB_PAR=1, order 9, reset, 2 enables -> o_data = 1,1,0; r = 0x1AA, 0x155, 0x0AA.
//  T2 Order 7, NB_PAR=1: exactly 127 enables return r to SEED[6:0]; no earlier repeat.
//   Order 15: period is 32767.
//  T3 Loopback gen->chk, NB_PAR=8, order 31: o_locked = 1 within 4+LOCK_CNT+2 valid words;
//   o_err_cnt stays 0 over 10^5 words.
//  T4 Locked, order 9, NB_PAR=1: flip one rx bit -> exactly 3 err pulses (bit, +5, +9 later);
//   o_err_cnt = 3; o_locked stays 1.
//  T5 Locked, drive all-ones -> every bit errors; o_locked = 0 after 4 words.
//   All-zero input never locks.
//  T6 Change i_order_sel mid-run -> r reloads SEED, o_locked = 0 next cycle.
//   Async reset mid-word -> all outputs at reset values. Saturation with CNT_W=4:
//   count holds at 15. i_clr_cnt and an error in the same cycle -> 0.

Source files
------------

// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pkg
//  Description : Order codes, polynomial lookups and checker state encodings
//                shared by the PRBS generator/checker.
//  Revision    : 1.0  initial release
// ============================================================================
package prbs_pkg;

    localparam int MAX_ORDER = 31;

    typedef enum logic [2:0] {
        ORD_PRBS7  = 3'd0,
        ORD_PRBS9  = 3'd1,
        ORD_PRBS15 = 3'd2,
        ORD_PRBS23 = 3'd3,
        ORD_PRBS31 = 3'd4
    } order_e;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

    // Codes 5..7 alias to PRBS31.
    function automatic order_e norm_order(input logic [2:0] sel);
        if (sel > 3'd4) return ORD_PRBS31;
        return order_e'(sel);
    endfunction

    // Index of the register MSB (order - 1).
    function automatic logic [4:0] order_msb(input order_e o);
        case (o)
            ORD_PRBS7:  return 5'd6;
            ORD_PRBS9:  return 5'd8;
            ORD_PRBS15: return 5'd14;
            ORD_PRBS23: return 5'd22;
            default:    return 5'd30;
        endcase
    endfunction

    // Index of the feedback tap (tap - 1).
    function automatic logic [4:0] order_tap(input order_e o);
        case (o)
            ORD_PRBS7:  return 5'd5;
            ORD_PRBS9:  return 5'd4;
            ORD_PRBS15: return 5'd13;
            ORD_PRBS23: return 5'd17;
            default:    return 5'd27;
        endcase
    endfunction

    function automatic logic [MAX_ORDER-1:0] order_mask(input order_e o);
        case (o)
            ORD_PRBS7:  return 31'h0000_007F;
            ORD_PRBS9:  return 31'h0000_01FF;
            ORD_PRBS15: return 31'h0000_7FFF;
            ORD_PRBS23: return 31'h007F_FFFF;
            default:    return 31'h7FFF_FFFF;
        endcase
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [MAX_ORDER-1:0] seed_for(input logic [MAX_ORDER-1:0] seed,
                                                      input order_e o);
        logic [MAX_ORDER-1:0] s;
        s = seed & order_mask(o);
        if (s == '0) s = 31'd1;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_gen_chk_if.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_gen_chk_if
//  Description : Control, pattern and status bundle of the PRBS generator/checker.
//  Revision    : 1.0  initial release
// ============================================================================
interface prbs_gen_chk_if #(
    parameter int NB_PAR = 1,
    parameter int CNT_W  = 32
) ();
    logic [2:0]        i_order_sel;
    logic              i_enable;
    logic [NB_PAR-1:0] o_data;
    logic              i_rx_valid;
    logic [NB_PAR-1:0] i_rx_data;
    logic              i_clr_cnt;
    logic              o_locked;
    logic [NB_PAR-1:0] o_err_bits;
    logic [CNT_W-1:0]  o_err_cnt;

    modport master (
        output i_order_sel, i_enable, i_rx_valid, i_rx_data, i_clr_cnt,
        input  o_data, o_locked, o_err_bits, o_err_cnt
    );

    modport slave (
        input  i_order_sel, i_enable, i_rx_valid, i_rx_data, i_clr_cnt,
        output o_data, o_locked, o_err_bits, o_err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/prbs_step.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_step
//  Description : NB_PAR serial LFSR steps unrolled in one cycle. Generator mode
//                emits pattern bits; checker mode shifts in received bits and
//                emits per-bit mismatches against the prediction.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_step
    import prbs_pkg::*;
#(
    parameter int NB_PAR = 1
) (
    input  wire logic [MAX_ORDER-1:0] i_state,
    input  wire logic [2:0]           i_order,
    input  wire logic                 i_chk_mode,
    input  wire logic [NB_PAR-1:0]    i_rx_bits,
    output logic      [MAX_ORDER-1:0] o_state,
    output logic      [NB_PAR-1:0]    o_bits
);

    logic [4:0]           w_msb;
    logic [4:0]           w_tap;
    logic [MAX_ORDER-1:0] w_mask;
    logic [MAX_ORDER-1:0] w_s;
    logic [NB_PAR-1:0]    w_rx;
    logic [NB_PAR-1:0]    w_out;
    logic                 w_in;
    logic                 w_fb;
    logic                 w_bit;
    logic                 w_new;

    assign w_msb  = order_msb(order_e'(i_order));
    assign w_tap  = order_tap(order_e'(i_order));
    assign w_mask = order_mask(order_e'(i_order));

    // Bit NB_PAR-1 is earliest in time, so rx is consumed MSB-first and out
    // bits are shifted in from the LSB side.
    always_comb begin
        w_s   = i_state;
        w_rx  = i_rx_bits;
        w_out = '0;
        w_in  = 1'b0;
        w_fb  = 1'b0;
        w_bit = 1'b0;
        w_new = 1'b0;
        for (int k = 0; k < NB_PAR; k++) begin
            w_in  = w_rx[NB_PAR-1];
            w_fb  = w_s[w_msb] ^ w_s[w_tap];
            w_bit = i_chk_mode ? (w_in ^ w_fb) : w_s[w_msb];
            w_new = i_chk_mode ? w_in : w_fb;
            w_out = (w_out << 1) | NB_PAR'(w_bit);
            w_rx  = w_rx << 1;
            w_s   = ((w_s << 1) | {{(MAX_ORDER-1){1'b0}}, w_new}) & w_mask;
        end
        o_state = w_s;
        o_bits  = w_out;
    end

endmodule
`default_nettype wire

// File: rtl/prbs_gen_chk.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_gen_chk
//  Description : Multi-order N-bit-parallel PRBS generator plus self-synchronising
//                checker with lock FSM and saturating error counter.
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int                   NB_PAR     = 1,
    parameter logic [MAX_ORDER-1:0] SEED       = 31'h1AA,
    parameter int                   LOCK_CNT   = 8,
    parameter int                   UNLOCK_CNT = 4,
    parameter int                   CNT_W      = 32
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,
    prbs_gen_chk_if.slave      bus
);

    localparam int c_run_max = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int c_run_w   = $clog2(c_run_max + 1);
    localparam int c_sum_w   = CNT_W + 6;

    localparam logic [c_run_w-1:0]   c_lock     = c_run_w'(LOCK_CNT);
    localparam logic [c_run_w-1:0]   c_unlock   = c_run_w'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0]     c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [MAX_ORDER-1:0] c_seed_rst = seed_for(SEED, ORD_PRBS7);

    order_e               r_order;
    logic [MAX_ORDER-1:0] r_gen_state;
    logic [MAX_ORDER-1:0] r_hist;
    chk_state_e           r_state;
    logic [c_run_w-1:0]   r_run_cnt;
    logic [NB_PAR-1:0]    r_err_bits;
    logic [CNT_W-1:0]     r_err_cnt;

    order_e               w_order_in;
    logic                 w_order_chg;
    logic [MAX_ORDER-1:0] w_gen_nxt;
    logic [NB_PAR-1:0]    w_gen_bits;
    logic [MAX_ORDER-1:0] w_hist_nxt;
    logic [NB_PAR-1:0]    w_chk_err;
    logic                 w_word_err;
    logic                 w_word_good;
    logic                 w_chk_upd;
    chk_state_e           w_state_nxt;
    logic [c_run_w-1:0]   w_run_nxt;
    logic [c_run_w-1:0]   w_run_inc;
    logic [c_sum_w-1:0]   w_sum;

    prbs_step #(.NB_PAR(NB_PAR)) u_gen (
        .i_state    (r_gen_state),
        .i_order    (r_order),
        .i_chk_mode (1'b0),
        .i_rx_bits  ({NB_PAR{1'b0}}),
        .o_state    (w_gen_nxt),
        .o_bits     (w_gen_bits)
    );

    prbs_step #(.NB_PAR(NB_PAR)) u_chk (
        .i_state    (r_hist),
        .i_order    (r_order),
        .i_chk_mode (1'b1),
        .i_rx_bits  (bus.i_rx_data),
        .o_state    (w_hist_nxt),
        .o_bits     (w_chk_err)
    );

    assign w_order_in  = norm_order(bus.i_order_sel);
    assign w_order_chg = (w_order_in != r_order);
    // A word arriving in the same cycle as an order change is discarded.
    assign w_chk_upd   = bus.i_rx_valid && !w_order_chg;
    assign w_word_err  = |w_chk_err;
    // An all-zero history would predict zeros forever, so it never counts as good.
    assign w_word_good = !w_word_err && (w_hist_nxt != '0);
    assign w_run_inc   = r_run_cnt + 1'b1;
    assign w_sum       = {6'b0, r_err_cnt} + c_sum_w'($countones(w_chk_err));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_order     <= ORD_PRBS7;
            r_gen_state <= c_seed_rst;
            r_hist      <= '0;
            r_err_bits  <= '0;
        end else begin
            r_order <= w_order_in;
            if (w_order_chg) begin
                r_gen_state <= seed_for(SEED, w_order_in);
                r_hist      <= '0;
            end else begin
                if (bus.i_enable) r_gen_state <= w_gen_nxt;
                if (bus.i_rx_valid) begin
                    r_hist     <= w_hist_nxt;
                    r_err_bits <= w_chk_err;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_SEARCH;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        if (w_order_chg) begin
            w_state_nxt = ST_SEARCH;
            w_run_nxt   = '0;
        end else if (bus.i_rx_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    if (!w_word_good)            w_run_nxt = '0;
                    else if (w_run_inc == c_lock) begin
                        w_state_nxt = ST_LOCKED;
                        w_run_nxt   = '0;
                    end else                     w_run_nxt = w_run_inc;
                end
                ST_LOCKED: begin
                    if (!w_word_err)               w_run_nxt = '0;
                    else if (w_run_inc == c_unlock) begin
                        w_state_nxt = ST_SEARCH;
                        w_run_nxt   = '0;
                    end else                       w_run_nxt = w_run_inc;
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // Clear beats an increment in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err_cnt <= '0;
        end else if (bus.i_clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_chk_upd && (r_state == ST_LOCKED)) begin
            r_err_cnt <= (w_sum > {6'b0, c_cnt_max}) ? c_cnt_max : w_sum[CNT_W-1:0];
        end
    end

    assign bus.o_data     = w_gen_bits;
    assign bus.o_locked   = (r_state == ST_LOCKED);
    assign bus.o_err_bits = r_err_bits;
    assign bus.o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
